wb_stream_mux: RTL

Parametrised Wishbone-slave-to-stream bridge serving `NUM_CH` independent accelerator channels. Each channel has a TX FIFO (Wishbone writes to the accelerator input stream) and an RX FIFO (accelerator output stream to Wishbone reads), plus per-channel status and control registers. It sits between the Caravel user-area Wishbone bus and a bank of val/rdy accelerators, and generalises the single-channel, unbuffered bridge to multiple buffered channels with flow-control visibility.

---
 rtl/wb_stream_pkg.sv | 38 +++
 rtl/wb_stream_mux_fifo.sv | 57 +++++
 rtl/wb_stream_mux.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/wb_stream_pkg.sv
// Shared register map for the Wishbone-to-stream bridge: register offsets,
// STATUS field positions, CTRL bit positions and the STATUS word builder.
package wb_stream_pkg;

   localparam logic [1:0] REG_TX     = 2'd0;
   localparam logic [1:0] REG_RX     = 2'd1;
   localparam logic [1:0] REG_STATUS = 2'd2;
   localparam logic [1:0] REG_CTRL   = 2'd3;

   localparam int ST_TX_COUNT = 0;
   localparam int ST_RX_COUNT = 8;
   localparam int ST_TX_FULL  = 16;
   localparam int ST_RX_EMPTY = 17;
   localparam int ST_OVF      = 18;
   localparam int ST_UNF      = 19;

   localparam int CTRL_FLUSH_TX  = 0;
   localparam int CTRL_FLUSH_RX  = 1;
   localparam int CTRL_CLR_FLAGS = 2;

   function automatic logic [31:0] make_status(input logic [7:0] tx_count,
                                               input logic [7:0] rx_count,
                                               input logic       tx_full,
                                               input logic       rx_empty,
                                               input logic       ovf,
                                               input logic       unf);
      logic [31:0] s;
      s = '0;
      s[ST_TX_COUNT +: 8] = tx_count;
      s[ST_RX_COUNT +: 8] = rx_count;
      s[ST_TX_FULL]       = tx_full;
      s[ST_RX_EMPTY]      = rx_empty;
      s[ST_OVF]           = ovf;
      s[ST_UNF]           = unf;
      return s;
   endfunction

endpackage

// File: rtl/wb_stream_mux_fifo.sv
// Fall-through FIFO with push/pop/flush. A push while full is accepted only
// when a pop happens on the same edge; flush overrides both.
module stream_fifo #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   input  logic              flush,
   output logic [DATA_W-1:0] head,
   output logic [CW-1:0]     count,
   output logic              full,
   output logic              empty
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     rd_ptr;
   logic [AW-1:0]     wr_ptr;
   logic              do_push;
   logic              do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= push_data;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/wb_stream_mux.sv
// Wishbone slave bridging NUM_CH buffered val/rdy accelerator channels:
// per-channel TX/RX FIFOs, sticky overflow/underflow flags, STATUS/CTRL regs.
module wb_stream_mux
   import wb_stream_pkg::*;
#(
   parameter int          NUM_CH    = 2,
   parameter int          DATA_W    = 32,
   parameter int          DEPTH     = 4,
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wbs_stb_i,
   input  logic                     wbs_cyc_i,
   input  logic                     wbs_we_i,
   input  logic [3:0]               wbs_sel_i,
   input  logic [31:0]              wbs_dat_i,
   input  logic [31:0]              wbs_adr_i,
   output logic                     wbs_ack_o,
   output logic [31:0]              wbs_dat_o,
   output logic [NUM_CH-1:0]        i_stream_val,
   output logic [NUM_CH*DATA_W-1:0] i_stream_data,
   input  logic [NUM_CH-1:0]        i_stream_rdy,
   input  logic [NUM_CH-1:0]        o_stream_val,
   input  logic [NUM_CH*DATA_W-1:0] o_stream_data,
   output logic [NUM_CH-1:0]        o_stream_rdy
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic        hit;
   logic [7:0]  ch_idx;
   logic [1:0]  reg_idx;
   logic        wr_tx;
   logic        rd_rx;
   logic        rd_status;
   logic        wr_ctrl;
   logic [31:0] rd_data;
   logic        unused_bits;

   logic [NUM_CH-1:0][31:0] status_word;
   logic [NUM_CH-1:0][31:0] rx_word;

   // The ack term makes every request occupy two cycles, so a held strobe
   // is never decoded twice.
   assign hit       = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o &
                      ((wbs_adr_i & ~32'hFFF) == BASE_ADDR);
   assign ch_idx    = wbs_adr_i[11:4];
   assign reg_idx   = wbs_adr_i[3:2];
   assign wr_tx     = hit &  wbs_we_i & (reg_idx == REG_TX);
   assign rd_rx     = hit & ~wbs_we_i & (reg_idx == REG_RX);
   assign rd_status = hit & ~wbs_we_i & (reg_idx == REG_STATUS);
   assign wr_ctrl   = hit &  wbs_we_i & (reg_idx == REG_CTRL);

   assign unused_bits = ^{wbs_sel_i, wbs_dat_i, wbs_adr_i[1:0]};

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      localparam logic [7:0] CH = 8'(c);

      logic              sel;
      logic              tx_push, tx_pop, tx_flush, tx_full, tx_empty;
      logic              rx_push, rx_pop, rx_flush, rx_full, rx_empty;
      logic              clr_flags;
      logic              ovf, unf;
      logic [CW-1:0]     tx_count, rx_count;
      logic [DATA_W-1:0] rx_head;

      assign sel       = (ch_idx == CH);
      assign tx_push   = wr_tx & sel;
      assign tx_pop    = i_stream_val[c] & i_stream_rdy[c];
      assign tx_flush  = wr_ctrl & sel & wbs_dat_i[CTRL_FLUSH_TX];
      assign rx_pop    = rd_rx & sel;
      assign rx_push   = o_stream_val[c] & o_stream_rdy[c];
      assign rx_flush  = wr_ctrl & sel & wbs_dat_i[CTRL_FLUSH_RX];
      assign clr_flags = wr_ctrl & sel & wbs_dat_i[CTRL_CLR_FLAGS];

      stream_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_tx (
         .clk       (clk),
         .reset     (reset),
         .push      (tx_push),
         .push_data (wbs_dat_i[DATA_W-1:0]),
         .pop       (tx_pop),
         .flush     (tx_flush),
         .head      (i_stream_data[c*DATA_W +: DATA_W]),
         .count     (tx_count),
         .full      (tx_full),
         .empty     (tx_empty)
      );

      stream_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rx (
         .clk       (clk),
         .reset     (reset),
         .push      (rx_push),
         .push_data (o_stream_data[c*DATA_W +: DATA_W]),
         .pop       (rx_pop),
         .flush     (rx_flush),
         .head      (rx_head),
         .count     (rx_count),
         .full      (rx_full),
         .empty     (rx_empty)
      );

      assign i_stream_val[c] = ~tx_empty;
      assign o_stream_rdy[c] = ~rx_full;

      // A full-FIFO write is only lost when no stream pop frees a slot that edge.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            ovf <= 1'b0;
            unf <= 1'b0;
         end else if (clr_flags) begin
            ovf <= 1'b0;
            unf <= 1'b0;
         end else begin
            if (tx_push & tx_full & ~tx_pop)
               ovf <= 1'b1;
            if (rx_pop & rx_empty)
               unf <= 1'b1;
         end
      end

      assign status_word[c] = make_status(8'(tx_count), 8'(rx_count),
                                          tx_full, rx_empty, ovf, unf);
      assign rx_word[c]     = rx_empty ? 32'h0 : 32'(rx_head);
   end

   // Channels beyond NUM_CH never match, so they read back as zero.
   always_comb begin
      rd_data = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (ch_idx == 8'(c)) begin
            if (rd_rx)
               rd_data = rx_word[c];
            else if (rd_status)
               rd_data = status_word[c];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wbs_ack_o <= 1'b0;
         wbs_dat_o <= '0;
      end else begin
         wbs_ack_o <= hit;
         wbs_dat_o <= rd_data;
      end
   end

endmodule
